// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: access sizes, FSM states,
// memory operation codes, owner tags and the transfer-length helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_op_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int FETCH_BYTES = 4;

  // Number of byte cycles for a load/store of the given size.
  function automatic logic [2:0] xfer_len(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and byte-memory signals around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic                  if_ready;
  logic [LEN-1:0]        if_inst;

  logic                  ls_req;
  logic                  ls_we;
  logic [1:0]            ls_size;
  logic                  ls_signed;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [LEN-1:0]        ls_wdata;
  logic                  ls_ready;
  logic [LEN-1:0]        ls_rdata;

  logic [ADDR_WIDTH-1:0] mem_a;
  logic [7:0]            mem_dout;
  logic                  mem_wr;
  logic [7:0]            mem_din;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
    input  mem_din,
    output if_ready, if_inst, ls_ready, ls_rdata,
    output mem_a, mem_dout, mem_wr
  );

  modport master (
    output if_req, if_addr, if_flush,
    output ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
    output mem_din,
    input  if_ready, if_inst, ls_ready, ls_rdata,
    input  mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/mem_arbiter_load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
module mem_arbiter_load_extend
  import mem_arbiter_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] word,
  input  logic [1:0]     size,
  input  logic           sgn,
  output logic [LEN-1:0] ext
);

  // Byte and half results are widened; words pass straight through.
  always_comb begin
    ext = word;
    case (size)
      SZ_BYTE: ext = {{(LEN-8){sgn & word[7]}}, word[7:0]};
      SZ_HALF: ext = {{(LEN-16){sgn & word[15]}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store onto a
// byte-wide, 1-cycle-latency memory. One access in flight at a time.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no access; grant a pending request at the edge
//   ST_READ  | drive read addresses, capture returning bytes
//   ST_WRITE | drive mem_wr with one byte per cycle
//   ST_DONE  | ready pulse to the owner; may grant again at the edge
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  state_e                state, state_nxt;
  owner_e                owner;
  mem_op_e               mem_op;
  logic                  prio_ls;
  logic                  flushed;
  logic                  can_grant, if_want, gnt_if, gnt_ls;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            mem_dout_q;
  logic [2:0]            len_q, left_q;
  logic [1:0]            size_q, lane;
  logic                  sgn_q, cap_en;
  logic [LEN-1:0]        wsh_q, rbuf_q, rd_word, ext_word;
  logic [LEN-1:0]        if_inst_q, ls_rdata_q;

  // Grant decision; a flush in the same cycle hides the fetch request.
  always_comb begin
    can_grant = (state == ST_IDLE) || (state == ST_DONE);
    if_want   = bus.if_req && !bus.if_flush;
    gnt_ls    = can_grant && bus.ls_req && (!if_want || prio_ls);
    gnt_if    = can_grant && if_want && !gnt_ls;
  end

  // Byte lane being captured this cycle merged over the bytes gathered so far.
  always_comb begin
    cap_en  = (state == ST_READ) && (left_q != len_q);
    lane    = 2'(len_q - left_q - 3'd1);
    rd_word = rbuf_q;
    if (cap_en) rd_word[8*lane +: 8] = bus.mem_din;
  end

  mem_arbiter_load_extend #(.LEN(LEN)) u_load_extend (
    .word (rd_word),
    .size (size_q),
    .sgn  (sgn_q),
    .ext  (ext_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; left_q counts down the remaining cycles of the phase.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (gnt_if) begin
          state_nxt = ST_READ;
        end else if (gnt_ls) begin
          if (bus.ls_size == SZ_ILL) state_nxt = ST_DONE;
          else if (bus.ls_we)        state_nxt = ST_WRITE;
          else                       state_nxt = ST_READ;
        end
      end
      ST_READ:  if (left_q == 3'd0) state_nxt = ST_DONE;
      ST_WRITE: if (left_q == 3'd1) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; mem_wr falls with the async state reset.
  always_comb begin
    mem_op = MEM_NOP;
    if (state == ST_READ)       mem_op = MEM_READ;
    else if (state == ST_WRITE) mem_op = MEM_WRITE;
    bus.mem_wr   = (mem_op == MEM_WRITE);
    bus.if_ready = (state == ST_DONE) && (owner == OWN_IF) && !flushed && !bus.if_flush;
    bus.ls_ready = (state == ST_DONE) && (owner == OWN_LS);
  end

  // Access datapath: latch at grant, step address/data, assemble results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_IF;
      prio_ls    <= 1'b1;
      flushed    <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      len_q      <= '0;
      left_q     <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      wsh_q      <= '0;
      rbuf_q     <= '0;
      if_inst_q  <= '0;
      ls_rdata_q <= '0;
    end else if (gnt_if || gnt_ls) begin
      prio_ls <= gnt_if;
      owner   <= gnt_ls ? OWN_LS : OWN_IF;
      flushed <= 1'b0;
      rbuf_q  <= '0;
      if (gnt_if) begin
        mem_a_q <= bus.if_addr;
        len_q   <= 3'(FETCH_BYTES);
        left_q  <= 3'(FETCH_BYTES);
        size_q  <= SZ_WORD;
        sgn_q   <= 1'b0;
      end else begin
        len_q  <= xfer_len(bus.ls_size);
        left_q <= xfer_len(bus.ls_size);
        size_q <= bus.ls_size;
        sgn_q  <= bus.ls_signed;
        wsh_q  <= bus.ls_wdata >> 8;
        if (bus.ls_size == SZ_ILL) begin
          ls_rdata_q <= '0;
        end else begin
          mem_a_q <= bus.ls_addr;
          if (bus.ls_we) mem_dout_q <= bus.ls_wdata[7:0];
        end
      end
    end else if (state == ST_READ) begin
      left_q <= left_q - 3'd1;
      if (left_q > 3'd1) mem_a_q <= mem_a_q + 1'b1;
      if (cap_en) rbuf_q <= rd_word;
      if (owner == OWN_IF && bus.if_flush) flushed <= 1'b1;
      if (left_q == 3'd0) begin
        if (owner == OWN_LS)                    ls_rdata_q <= ext_word;
        else if (!flushed && !bus.if_flush)     if_inst_q  <= rd_word;
      end
    end else if (state == ST_WRITE) begin
      left_q <= left_q - 3'd1;
      if (left_q > 3'd1) begin
        mem_a_q    <= mem_a_q + 1'b1;
        mem_dout_q <= wsh_q[7:0];
        wsh_q      <= wsh_q >> 8;
      end
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte memory model, scoreboard of expected ready
// events, directed sequences for fetch, loads, stores, flush and reset.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        is_ls;
    logic        chk_data;
    logic [31:0] data;
  } sb_item_t;

  sb_item_t    sb_q[$];
  sb_item_t    e;
  logic [24:0] wr_log[$];
  logic [7:0]  mem [0:131071];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void sb_push(input logic is_ls, input logic chk_data, input logic [31:0] data);
    sb_item_t it;
    it.is_ls    = is_ls;
    it.chk_data = chk_data;
    it.data     = data;
    sb_q.push_back(it);
  endfunction

  // Byte memory: read data appears one cycle after the address.
  always @(posedge clk) begin
    bus.mem_din <= mem[bus.mem_a];
    if (bus.mem_wr) begin
      mem[bus.mem_a] <= bus.mem_dout;
      wr_log.push_back({bus.mem_a, bus.mem_dout});
    end
  end

  // Every ready pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (bus.if_ready || bus.ls_ready)) begin
      chk("both_ready", 64'(bus.if_ready & bus.ls_ready), 0);
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", {bus.if_ready, bus.ls_ready}, 0);
      end else begin
        e = sb_q.pop_front();
        chk("ready_src", bus.ls_ready, e.is_ls);
        if (e.chk_data) chk("rdata", e.is_ls ? bus.ls_rdata : bus.if_inst, e.data);
      end
    end
  end

  task automatic do_fetch(input logic [16:0] addr, input logic [31:0] exp);
    int cnt = 0;
    sb_push(1'b0, 1'b1, exp);
    @(negedge clk);
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt <= 4) chk("fetch_mem_a", bus.mem_a, 17'(addr + 17'(cnt - 1)));
    end while (!bus.if_ready && cnt < 40);
    bus.if_req = 1'b0;
    chk("fetch_lat", cnt, 6);
  endtask

  task automatic do_ls(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [16:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input int lat);
    int cnt = 0;
    sb_push(1'b1, !we, exp);
    @(negedge clk);
    bus.ls_we     = we;
    bus.ls_size   = size;
    bus.ls_signed = sgn;
    bus.ls_addr   = addr;
    bus.ls_wdata  = wdata;
    bus.ls_req    = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.ls_ready && cnt < 40);
    bus.ls_req = 1'b0;
    chk("ls_lat", cnt, lat);
  endtask

  initial begin
    int if_cnt, ls_cnt, rdy_at, rdy_n;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h10] = 8'h13; mem[17'h11] = 8'h00; mem[17'h12] = 8'h00; mem[17'h13] = 8'h93;
    mem[17'h20] = 8'h80;
    mem[17'h24] = 8'h34; mem[17'h25] = 8'h92;
    mem[17'h30] = 8'h5A;
    mem[17'h40] = 8'h78; mem[17'h41] = 8'h56; mem[17'h42] = 8'h34; mem[17'h43] = 8'h12;
    mem[17'h50] = 8'hEF; mem[17'h51] = 8'hBE; mem[17'h52] = 8'hAD; mem[17'h53] = 8'hDE;
    mem[17'h70] = 8'hC3;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'b00; bus.ls_signed = 1'b0;
    bus.ls_addr = '0; bus.ls_wdata = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_ls_ready", bus.ls_ready, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_if_inst", bus.if_inst, 0);
    chk("rst_ls_rdata", bus.ls_rdata, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_dout", bus.mem_dout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention from reset: ls, if, ls.
    sb_push(1'b1, 1'b1, 32'h0000005A);
    sb_push(1'b0, 1'b1, 32'hDEADBEEF);
    sb_push(1'b1, 1'b1, 32'h12345678);
    bus.if_addr = 17'h50; bus.if_req = 1'b1;
    bus.ls_we = 1'b0; bus.ls_size = 2'b00; bus.ls_signed = 1'b0; bus.ls_addr = 17'h30;
    bus.ls_req = 1'b1;
    fork
      begin
        ls_cnt = 0;
        for (int c = 0; c < 60 && ls_cnt < 2; c++) begin
          @(negedge clk);
          if (bus.ls_ready) begin
            ls_cnt++;
            if (ls_cnt == 1) begin
              bus.ls_size = 2'b10; bus.ls_addr = 17'h40;
            end else begin
              bus.ls_req = 1'b0;
            end
          end
        end
        bus.ls_req = 1'b0;
      end
      begin
        if_cnt = 0;
        for (int c = 0; c < 60 && if_cnt < 1; c++) begin
          @(negedge clk);
          if (bus.if_ready) begin
            if_cnt++;
            bus.if_req = 1'b0;
          end
        end
        bus.if_req = 1'b0;
      end
    join
    chk("cont_ls_readies", ls_cnt, 2);
    chk("cont_if_readies", if_cnt, 1);
    repeat (2) @(negedge clk);

    // Word fetch with address sequence and latency.
    wr_log.delete();
    do_fetch(17'h10, 32'h93000013);

    // Byte and half loads, signed and unsigned.
    do_ls(1'b0, 2'b00, 1'b1, 17'h20, 32'h0, 32'hFFFFFF80, 3);
    do_ls(1'b0, 2'b00, 1'b0, 17'h20, 32'h0, 32'h00000080, 3);
    do_ls(1'b0, 2'b01, 1'b1, 17'h24, 32'h0, 32'hFFFF9234, 4);
    do_ls(1'b0, 2'b01, 1'b0, 17'h24, 32'h0, 32'h00009234, 4);
    chk("no_writes_on_reads", wr_log.size(), 0);

    // Half store wrapping past the top of memory.
    wr_log.delete();
    do_ls(1'b1, 2'b01, 1'b0, 17'h1FFFF, 32'hDEADBEEF, 32'h0, 3);
    chk("st_count", wr_log.size(), 2);
    chk("st_w0", wr_log[0], {17'h1FFFF, 8'hEF});
    chk("st_w1", wr_log[1], {17'h00000, 8'hBE});

    // Illegal size: immediate completion, zero data, no memory write.
    wr_log.delete();
    do_ls(1'b0, 2'b11, 1'b1, 17'h20, 32'h0, 32'h00000000, 1);
    do_ls(1'b1, 2'b11, 1'b0, 17'h20, 32'hFFFFFFFF, 32'h0, 1);
    chk("ill_no_write", wr_log.size(), 0);

    // Flush mid-fetch, then a pending load granted as the FSM frees up.
    sb_push(1'b1, 1'b1, 32'h000000C3);
    @(negedge clk);
    bus.if_addr = 17'h60; bus.if_req = 1'b1;
    if_cnt = 0; rdy_at = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i <= 4) chk("flush_mem_a", bus.mem_a, 17'(17'h60 + 17'(i - 1)));
      if (i == 7) chk("flush_ls_grant_a", bus.mem_a, 17'h70);
      if (bus.if_ready) if_cnt++;
      if (bus.ls_ready && rdy_at == 0) begin
        rdy_at = i;
        bus.ls_req = 1'b0;
      end
      if (i == 2) begin
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
      end
      if (i == 3) begin
        bus.if_flush = 1'b0;
        bus.ls_we = 1'b0; bus.ls_size = 2'b00; bus.ls_signed = 1'b0; bus.ls_addr = 17'h70;
        bus.ls_req = 1'b1;
      end
    end
    bus.ls_req = 1'b0;
    chk("flush_no_if_ready", if_cnt, 0);
    chk("flush_ls_ready_at", rdy_at, 9);

    // Reset during write cycle 2 of a word store.
    wr_log.delete();
    @(negedge clk);
    bus.ls_we = 1'b1; bus.ls_size = 2'b10; bus.ls_addr = 17'h100; bus.ls_wdata = 32'h11223344;
    bus.ls_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_wr_before", bus.mem_wr, 1);
    rst_n = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    chk("rst_mid_wr_async", bus.mem_wr, 0);
    chk("rst_mid_wr_count", wr_log.size(), 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ls_ready) rdy_n++;
    end
    chk("rst_mid_no_ready", rdy_n, 0);
    chk("rst_mid_no_more_wr", wr_log.size(), 2);
    chk("rst_mid_mem_a", bus.mem_a, 0);

    // Arbiter is idle and usable after the aborted access.
    do_fetch(17'h10, 32'h93000013);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, memory byte-address width.
REQ-002 Parameter LEN, default 32, instruction/data word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch request; held until if_ready.
REQ-006 if_addr  in  ADDR_WIDTH  fetch byte address.
REQ-007 if_flush  in  1  discard an in-flight or pending fetch.
REQ-008 if_ready  out  1  one-cycle pulse: if_inst valid.
REQ-009 if_inst  out  LEN  fetched word, little-endian.
REQ-010 ls_req  in  1  load/store request; held until ls_ready.
REQ-011 ls_we  in  1  1 = store, 0 = load.
REQ-012 ls_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-013 ls_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-014 ls_addr  in  ADDR_WIDTH  data byte address.
REQ-015 ls_wdata  in  LEN  store data; low bytes used.
REQ-016 ls_ready  out  1  one-cycle pulse: access complete, ls_rdata valid for loads.
REQ-017 ls_rdata  out  LEN  extended load result.
REQ-018 mem_a  out  ADDR_WIDTH  byte address to memory.
REQ-019 mem_dout  out  8  write byte.
REQ-020 mem_wr  out  1  1 = write mem_dout at mem_a this cycle.
REQ-021 mem_din  in  8  read byte, valid the cycle after its address is driven (1-cycle latency).

Function
REQ-022 FSM states: IDLE, READ, WRITE, DONE; one access in flight at a time.
REQ-023 IDLE with exactly one request: grant that request at the edge.
REQ-024 IDLE with both if_req and ls_req: grant the requester not granted last (round-robin); the first contention after reset goes to ls.
REQ-025 At grant, latch address, size, sign, write data and owner; transfer length N = 4 for fetch, 1/2/4 for ls_size 00/01/10.
REQ-026 ls_size 11: no memory cycle; go to DONE; ls_ready pulses the next cycle with ls_rdata = 0.
REQ-027 READ: drive mem_a = base+k in cycles k = 0..N-1 after grant; capture mem_din into byte lane k at the edge ending cycle k+1.
REQ-028 WRITE: drive mem_wr = 1, mem_a = base+k, mem_dout = wdata byte k in cycles k = 0..N-1 after grant.
REQ-029 Address increment wraps modulo 2^ADDR_WIDTH.
REQ-030 Completion: ready pulses exactly one cycle, N+1 cycles after grant for reads and N cycles after grant for writes; FSM returns to IDLE and may grant again at the same edge that ends the ready cycle.
REQ-031 Loads: byte/half results are extended per ls_signed; upper bits of if_inst and word loads are taken directly from the 4 bytes.
REQ-032 if_flush during a granted fetch: memory reads complete, if_ready is suppressed, and the round-robin pointer still updates.
REQ-033 if_flush in IDLE: if_req is ignored in that cycle.
REQ-034 Requester deasserting req mid-access does not abort the access.
REQ-035 mem_wr = 0 and mem_a holds its last value in IDLE and DONE; no write is ever issued for a fetch or a load.

Reset
REQ-036 rst_n low: state IDLE; if_ready, ls_ready and mem_wr = 0; if_inst, ls_rdata, mem_a and mem_dout = 0; round-robin pointer = ls-first.
REQ-037 Reset asserted mid-access aborts it immediately (mem_wr drops asynchronously); no ready pulse is issued for the aborted access.

Structure
REQ-038 Size encodings, FSM state encodings and the MEM_NOP/READ/WRITE codes live in the shared defines file.
REQ-039 One sub-module, load_extend (combinational byte/half sign/zero extension), is natural; the arbitration and FSM stay in mem_arbiter.

Verification
REQ-040 Word fetch at 0x00010, memory bytes 13 00 00 93 -> mem_a 0x10..0x13 on consecutive cycles, if_ready 5 cycles after grant, if_inst = 0x93000013.
REQ-041 Signed byte load of 0x80 at 0x00020 -> ls_rdata = 0xFFFFFF80; same load unsigned -> 0x00000080.
REQ-042 Half store of 0xDEADBEEF at 0x1FFFF -> mem_wr 2 cycles, writes 0xEF@0x1FFFF and 0xBE@0x00000, ls_ready in cycle 2.
REQ-043 if_req and ls_req asserted together, held for 3 accesses -> grants ls, if, ls; each requester sees exactly one ready per grant.
REQ-044 if_flush pulsed mid-fetch -> 4 reads issued, no if_ready; a following ls_req is granted on return to IDLE.
REQ-045 rst_n low in write cycle 2 of a word store -> mem_wr drops immediately, no ls_ready, state IDLE after release.
